// File: rtl/spi_slave_with_single_cs_pkg.sv
// Shared definitions for the SPI responder: byte width, FSM state type and
// helpers that split SPI_MODE into clock polarity and phase.
package spi_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_state_t;

    function automatic logic cpol(input int mode);
        return mode[1];
    endfunction

    function automatic logic cpha(input int mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_slave_with_single_cs_sync_edge.sv
// Two-flop synchroniser for an asynchronous SPI pin, plus single-cycle rise and
// fall strobes derived from the synchronised value and its delayed copy.
module spi_sync_edge #(
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= IDLE_LVL;
            sync <= IDLE_LVL;
            prev <= IDLE_LVL;
        end else begin
            meta <= async_in;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slave_with_single_cs.sv
// SPI responder with one chip select, oversampled in the i_Clk domain: receives
// MOSI bytes, returns preloaded bytes on MISO and counts bytes per CS assertion.
module spi_slave_with_single_cs
    import spi_pkg::*;
#(
    parameter int          SPI_MODE         = 0,
    parameter int          MAX_BYTES_PER_CS = 2,
    parameter logic [7:0]  TX_IDLE_BYTE     = 8'hFF,
    localparam int         CW               = $clog2(MAX_BYTES_PER_CS + 1)
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [BYTE_W-1:0] i_TX_Byte,
    input  logic              i_TX_DV,
    output logic              o_TX_Ready,
    output logic              o_RX_DV,
    output logic [BYTE_W-1:0] o_RX_Byte,
    output logic [CW-1:0]     o_RX_Count,
    output logic              o_CS_Active,
    input  logic              i_SPI_Clk,
    input  logic              i_SPI_CS_n,
    input  logic              i_SPI_MOSI,
    output logic              o_SPI_MISO,
    output logic              o_SPI_MISO_En
);

    localparam logic CPOL = cpol(SPI_MODE);
    localparam logic CPHA = cpha(SPI_MODE);

    logic              sck_s, sck_rise, sck_fall;
    logic              cs_n_s, cs_rise, cs_fall;
    logic              mosi_meta, mosi_s;
    spi_state_t        state;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] rx_sr, tx_sr, hold, load_byte;
    logic              hold_full;
    logic [CW-1:0]     rx_idx;
    logic              sck_edge, leading, trailing, sample_edge, shift_edge;
    logic              cs_start, byte_done, load;

    spi_sync_edge #(.IDLE_LVL(CPOL)) u_sck_sync (
        .clk      (i_Clk),
        .rst      (i_Rst),
        .async_in (i_SPI_Clk),
        .sync     (sck_s),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    spi_sync_edge #(.IDLE_LVL(1'b1)) u_cs_sync (
        .clk      (i_Clk),
        .rst      (i_Rst),
        .async_in (i_SPI_CS_n),
        .sync     (cs_n_s),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    // MOSI shares the SCK sync depth so data and its edge line up.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            mosi_meta <= i_SPI_MOSI;
            mosi_s    <= mosi_meta;
        end
    end

    // Leading edge moves SCK away from its idle level; trailing returns to it.
    assign sck_edge    = sck_rise | sck_fall;
    assign leading     = sck_edge & (sck_s != CPOL);
    assign trailing    = sck_edge & (sck_s == CPOL);
    assign sample_edge = (state == ACTIVE) & (CPHA ? trailing : leading);
    assign shift_edge  = (state == ACTIVE) & (CPHA ? leading : trailing);
    assign cs_start    = (state == IDLE) & cs_fall;
    assign byte_done   = sample_edge & (bit_cnt == 3'd7);
    assign load        = cs_start | byte_done;
    assign load_byte   = hold_full ? hold : (i_TX_DV ? i_TX_Byte : TX_IDLE_BYTE);
    assign o_TX_Ready  = ~hold_full;
    assign o_CS_Active = ~cs_n_s;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state         <= IDLE;
            bit_cnt       <= 3'd0;
            rx_sr         <= '0;
            tx_sr         <= TX_IDLE_BYTE;
            hold          <= '0;
            hold_full     <= 1'b0;
            rx_idx        <= '0;
            o_RX_DV       <= 1'b0;
            o_RX_Byte     <= '0;
            o_RX_Count    <= '0;
            o_SPI_MISO    <= TX_IDLE_BYTE[7];
            o_SPI_MISO_En <= 1'b0;
        end else begin
            o_RX_DV <= 1'b0;

            // A load takes the holding byte if present, else a coincident strobe directly.
            if (load) begin
                hold_full <= 1'b0;
            end else if (i_TX_DV && !hold_full) begin
                hold      <= i_TX_Byte;
                hold_full <= 1'b1;
            end

            if (state == IDLE) begin
                if (cs_fall) begin
                    state         <= ACTIVE;
                    bit_cnt       <= 3'd0;
                    rx_idx        <= '0;
                    o_SPI_MISO_En <= 1'b1;
                    if (!CPHA) begin
                        o_SPI_MISO <= load_byte[7];
                        tx_sr      <= {load_byte[6:0], 1'b0};
                    end else begin
                        tx_sr      <= load_byte;
                    end
                end
            end else begin
                if (sample_edge) begin
                    rx_sr   <= {rx_sr[6:0], mosi_s};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        o_RX_Byte  <= {rx_sr[6:0], mosi_s};
                        o_RX_DV    <= 1'b1;
                        o_RX_Count <= rx_idx;
                        rx_idx     <= (rx_idx == CW'(MAX_BYTES_PER_CS)) ? rx_idx : rx_idx + 1'b1;
                        tx_sr      <= load_byte;
                    end
                end
                if (shift_edge) begin
                    o_SPI_MISO <= tx_sr[7];
                    tx_sr      <= {tx_sr[6:0], 1'b0};
                end
                // CS release is handled after any byte completing in the same cycle.
                if (cs_rise) begin
                    state         <= IDLE;
                    bit_cnt       <= 3'd0;
                    o_SPI_MISO_En <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_with_single_cs.sv
// Drives all four SPI modes at once from a behavioural master and checks each
// responder against a queue model of preloaded bytes and expected RX order.
module tb_spi_slave_with_single_cs;

    localparam int H    = 4;
    localparam int MAXB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [7:0]      tx_byte;
    logic            tx_dv;
    logic            cs_n;
    logic [3:0]      sck, mosi;
    logic [3:0]      tx_ready, rx_dv, cs_active, miso, miso_en;
    logic [3:0][7:0] rx_byte;
    logic [3:0][1:0] rx_count;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_with_single_cs #(
            .SPI_MODE         (g),
            .MAX_BYTES_PER_CS (MAXB),
            .TX_IDLE_BYTE     (8'hFF)
        ) u_dut (
            .i_Clk         (clk),
            .i_Rst         (rst),
            .i_TX_Byte     (tx_byte),
            .i_TX_DV       (tx_dv),
            .o_TX_Ready    (tx_ready[g]),
            .o_RX_DV       (rx_dv[g]),
            .o_RX_Byte     (rx_byte[g]),
            .o_RX_Count    (rx_count[g]),
            .o_CS_Active   (cs_active[g]),
            .i_SPI_Clk     (sck[g]),
            .i_SPI_CS_n    (cs_n),
            .i_SPI_MOSI    (mosi[g]),
            .o_SPI_MISO    (miso[g]),
            .o_SPI_MISO_En (miso_en[g])
        );
    end

    int         vectors     = 0;
    int         miscompares = 0;
    int         ndv [4]     = '{default: 0};
    logic [7:0] got_byte [4][64];
    logic [1:0] got_cnt  [4][64];
    logic [7:0] exp_tx [$];
    logic [7:0] m_tx [4];
    logic [7:0] m_rx [4][4];
    logic [7:0] m_exp [5];

    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (rx_dv[m] === 1'b1) begin
                got_byte[m][ndv[m] % 64] <= rx_byte[m];
                got_cnt[m][ndv[m] % 64]  <= rx_count[m];
                ndv[m]                   <= ndv[m] + 1;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every load (CS start or byte end) consumes one queued byte or yields 0xFF.
    function automatic logic [7:0] next_tx();
        if (exp_tx.size() > 0) return exp_tx.pop_front();
        return 8'hFF;
    endfunction

    task automatic preload(input logic [7:0] b);
        for (int m = 0; m < 4; m++) begin
            vectors++;
            if (tx_ready[m] !== 1'b1) begin
                miscompares++;
                $display("FAIL preload_ready mode%0d: got %b expected 1", m, tx_ready[m]);
            end
        end
        tx_byte = b;
        tx_dv   = 1'b1;
        wait_clks(1);
        tx_dv   = 1'b0;
        for (int m = 0; m < 4; m++) begin
            vectors++;
            if (tx_ready[m] !== 1'b0) begin
                miscompares++;
                $display("FAIL preload_busy mode%0d: got %b expected 0", m, tx_ready[m]);
            end
        end
        exp_tx.push_back(b);
    endtask

    task automatic run_transfer(input int nb, input int stop_bits, input bit mid_pre,
                                input logic [7:0] mid_byte, input bit do_rst, input string tag);
        int base [4];
        int k, b, exp_dv;
        for (int m = 0; m < 4; m++) base[m] = ndv[m];
        cs_n     = 1'b0;
        m_exp[0] = next_tx();
        for (int m = 0; m < 4; m++) if (m[0] == 1'b0) mosi[m] = m_tx[0][7];
        wait_clks(2 * H);
        for (int m = 0; m < 4; m++) begin
            vectors++;
            if ({miso_en[m], cs_active[m]} !== 2'b11) begin
                miscompares++;
                $display("FAIL %s cs_on mode%0d: en/active got %b expected 11", tag, m, {miso_en[m], cs_active[m]});
            end
        end
        if (mid_pre) preload(mid_byte);
        for (int i = 0; i < nb * 8; i++) begin
            if (stop_bits > 0 && i == stop_bits) break;
            k = i / 8;
            b = 7 - (i % 8);
            for (int m = 0; m < 4; m++) if (m[0] == 1'b0) mosi[m] = m_tx[k][b];
            wait_clks(H);
            for (int m = 0; m < 4; m++) begin
                if (m[0] == 1'b1) mosi[m] = m_tx[k][b];
                else              m_rx[m][k] = {m_rx[m][k][6:0], miso[m]};
                sck[m] = ~m[1];
            end
            wait_clks(H);
            for (int m = 0; m < 4; m++) begin
                if (m[0] == 1'b1) m_rx[m][k] = {m_rx[m][k][6:0], miso[m]};
                sck[m] = m[1];
            end
            if (b == 0) m_exp[k + 1] = next_tx();
        end
        wait_clks(H);
        if (do_rst) begin
            rst = 1'b1;
            wait_clks(1);
            rst = 1'b0;
            exp_tx.delete();
            for (int m = 0; m < 4; m++) begin
                vectors++;
                if ({tx_ready[m], rx_dv[m], cs_active[m], miso[m], miso_en[m], rx_byte[m], rx_count[m]}
                    !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0}) begin
                    miscompares++;
                    $display("FAIL %s rst_vals mode%0d: rdy/dv/act/miso/en=%b byte=%h cnt=%0d expected 10010 00 0",
                             tag, m, {tx_ready[m], rx_dv[m], cs_active[m], miso[m], miso_en[m]}, rx_byte[m], rx_count[m]);
                end
            end
        end
        cs_n = 1'b1;
        wait_clks(3 * H);
        exp_dv = (stop_bits > 0 || do_rst) ? 0 : nb;
        for (int m = 0; m < 4; m++) begin
            vectors++;
            if ({miso_en[m], cs_active[m]} !== 2'b00) begin
                miscompares++;
                $display("FAIL %s cs_off mode%0d: en/active got %b expected 00", tag, m, {miso_en[m], cs_active[m]});
            end
            vectors++;
            if (ndv[m] - base[m] != exp_dv) begin
                miscompares++;
                $display("FAIL %s dv_count mode%0d: got %0d expected %0d", tag, m, ndv[m] - base[m], exp_dv);
            end
            for (int j = 0; j < exp_dv; j++) begin
                vectors++;
                if (got_byte[m][(base[m] + j) % 64] !== m_tx[j]) begin
                    miscompares++;
                    $display("FAIL %s rx_byte mode%0d #%0d: got %h expected %h", tag, m, j, got_byte[m][(base[m] + j) % 64], m_tx[j]);
                end
                vectors++;
                if (got_cnt[m][(base[m] + j) % 64] !== 2'((j < MAXB) ? j : MAXB)) begin
                    miscompares++;
                    $display("FAIL %s rx_count mode%0d #%0d: got %0d expected %0d", tag, m, j, got_cnt[m][(base[m] + j) % 64], (j < MAXB) ? j : MAXB);
                end
                vectors++;
                if (m_rx[m][j] !== m_exp[j]) begin
                    miscompares++;
                    $display("FAIL %s miso_byte mode%0d #%0d: got %h expected %h", tag, m, j, m_rx[m][j], m_exp[j]);
                end
            end
        end
    endtask

    task automatic test_reset();
        int base [4];
        rst     = 1'b1;
        cs_n    = 1'b1;
        tx_dv   = 1'b0;
        tx_byte = 8'h00;
        for (int m = 0; m < 4; m++) begin
            sck[m]  = m[1];
            mosi[m] = 1'b0;
        end
        wait_clks(3);
        rst = 1'b0;
        wait_clks(2);
        for (int m = 0; m < 4; m++) begin
            vectors++;
            if ({tx_ready[m], rx_dv[m], cs_active[m], miso[m], miso_en[m], rx_byte[m], rx_count[m]}
                !== {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0}) begin
                miscompares++;
                $display("FAIL reset mode%0d: rdy/dv/act/miso/en=%b byte=%h cnt=%0d expected 10010 00 0",
                         m, {tx_ready[m], rx_dv[m], cs_active[m], miso[m], miso_en[m]}, rx_byte[m], rx_count[m]);
            end
            base[m] = ndv[m];
        end
        // SCK activity with CS released must be ignored.
        for (int i = 0; i < 16; i++) begin
            for (int m = 0; m < 4; m++) begin
                sck[m]  = ~sck[m];
                mosi[m] = 1'($urandom_range(0, 1));
            end
            wait_clks(H);
        end
        wait_clks(2 * H);
        for (int m = 0; m < 4; m++) begin
            vectors++;
            if (ndv[m] != base[m] || miso_en[m] !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_sck mode%0d: dv=%0d en=%b expected dv=0 en=0", m, ndv[m] - base[m], miso_en[m]);
            end
        end
    endtask

    task automatic test_single();
        preload(8'hA5);
        m_tx[0] = 8'hC1;
        run_transfer(1, 0, 1'b0, 8'h00, 1'b0, "single");
        for (int m = 0; m < 4; m++) begin
            vectors++;
            if (tx_ready[m] !== 1'b1) begin
                miscompares++;
                $display("FAIL single_ready mode%0d: got %b expected 1", m, tx_ready[m]);
            end
        end
    endtask

    task automatic test_two_bytes();
        preload(8'h3C);
        m_tx[0] = 8'hC1;
        m_tx[1] = 8'hC2;
        run_transfer(2, 0, 1'b1, 8'h5A, 1'b0, "two_bytes");
    endtask

    task automatic test_no_preload();
        m_tx[0] = 8'h00;
        run_transfer(1, 0, 1'b0, 8'h00, 1'b0, "no_preload");
        for (int m = 0; m < 4; m++) begin
            vectors++;
            if (tx_ready[m] !== 1'b1) begin
                miscompares++;
                $display("FAIL no_preload_ready mode%0d: got %b expected 1", m, tx_ready[m]);
            end
        end
    endtask

    task automatic test_saturation();
        preload(8'($urandom));
        for (int k = 0; k < 4; k++) m_tx[k] = 8'($urandom);
        run_transfer(4, 0, 1'b1, 8'($urandom), 1'b0, "saturation");
    endtask

    task automatic test_abort();
        m_tx[0] = 8'($urandom);
        run_transfer(1, 3, 1'b0, 8'h00, 1'b0, "abort");
        m_tx[0] = 8'h81;
        run_transfer(1, 0, 1'b0, 8'h00, 1'b0, "after_abort");
    endtask

    task automatic test_reset_mid();
        m_tx[0] = 8'($urandom);
        run_transfer(1, 4, 1'b0, 8'h00, 1'b1, "reset_mid");
        preload(8'($urandom));
        m_tx[0] = 8'($urandom);
        run_transfer(1, 0, 1'b0, 8'h00, 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        int nb;
        bit mid;
        for (int t = 0; t < 6; t++) begin
            nb = int'($urandom_range(1, 4));
            for (int k = 0; k < 4; k++) m_tx[k] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) preload(8'($urandom));
            mid = 1'($urandom_range(0, 1));
            run_transfer(nb, 0, mid, 8'($urandom), 1'b0, "back_to_back");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_bytes();
        test_no_preload();
        test_saturation();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
